// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCK/WS/SD on clk, captures one channel's MSB-first word and
// presents it as a single-cycle pcm_ready_o strobe; truncated slots raise short_frame_o.
module i2s_rx #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter bit          CHANNEL      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    i2s_sck_i,
  input  logic                    i2s_ws_i,
  input  logic                    i2s_sd_i,
  output logic [SAMPLE_WIDTH-1:0] pcm_o,
  output logic                    pcm_ready_o,
  output logic                    short_frame_o
);

  localparam int unsigned CntW = $clog2(SLOT_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StAlign, StShift, StWaitEnd} state_e;

  // [0],[1]: two-flop synchronizer; [2]: delayed copy for edge detection
  logic [2:0] sck_q, ws_q, sd_q;

  logic sck_rise, ws_smp, sd_smp;
  logic ws_prev_q;
  logic [1:0] arm_q;
  logic ws_trans, ws_match;

  state_e                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic [SAMPLE_WIDTH-1:0] pcm_q, pcm_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                    rdy_q, rdy_d;
  logic                    sf_q, sf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= '0;
      ws_q  <= '0;
      sd_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], i2s_sck_i};
      ws_q  <= {ws_q[1:0], i2s_ws_i};
      sd_q  <= {sd_q[1:0], i2s_sd_i};
    end
  end

  // WS/SD are taken from the delayed stage: the value held just before SCK went high.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ws_smp   = ws_q[2];
  assign sd_smp   = sd_q[2];

  // The first two SCK rises after reset only prime ws_prev, so a stale reset value
  // can never masquerade as a slot boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_prev_q <= 1'b0;
      arm_q     <= '0;
    end else if (sck_rise) begin
      ws_prev_q <= ws_smp;
      arm_q     <= {arm_q[0], 1'b1};
    end
  end

  assign ws_trans = sck_rise & arm_q[1] & (ws_smp != ws_prev_q);
  assign ws_match = ws_trans & (ws_smp == CHANNEL);

  assign shift_nxt = (shift_q << 1) | SAMPLE_WIDTH'(sd_smp);
  assign cnt_inc   = (cnt_q == CntW'(SLOT_WIDTH)) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pcm_d   = pcm_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;
    sf_d    = 1'b0;

    if (!enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle, StWaitEnd: begin
          if (ws_match) begin
            state_d = StAlign;
            cnt_d   = '0;
          end else if (sck_rise && state_q == StWaitEnd) begin
            // Trailing slot bits are counted but otherwise ignored
            cnt_d = cnt_inc;
          end
        end

        StAlign: begin
          if (ws_trans) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (sck_rise) begin
            shift_d = SAMPLE_WIDTH'(sd_smp);
            cnt_d   = CntW'(1);
            if (SAMPLE_WIDTH == 1) begin
              pcm_d   = SAMPLE_WIDTH'(sd_smp);
              rdy_d   = 1'b1;
              state_d = StWaitEnd;
            end else begin
              state_d = StShift;
            end
          end
        end

        StShift: begin
          if (ws_trans) begin
            // Slot ended early: drop the partial word, then treat this edge as a fresh boundary
            sf_d    = 1'b1;
            cnt_d   = '0;
            state_d = ws_match ? StAlign : StIdle;
          end else if (sck_rise) begin
            shift_d = shift_nxt;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(SAMPLE_WIDTH - 1)) begin
              pcm_d   = shift_nxt;
              rdy_d   = 1'b1;
              state_d = StWaitEnd;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      pcm_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pcm_q   <= pcm_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      sf_q    <= sf_d;
    end
  end

  assign pcm_o         = pcm_q;
  assign pcm_ready_o   = rdy_q;
  assign short_frame_o = sf_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: one left-channel and one right-channel receiver share a
// synthetic I2S stream running at 1/16 of clk.
module tb_i2s_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic sck = 1'b0;
  logic ws = 1'b0;
  logic sd = 1'b0;

  logic [15:0] pcm0, pcm1;
  logic        rdy0, rdy1, sf0, sf1;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable),
    .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
    .pcm_o(pcm0), .pcm_ready_o(rdy0), .short_frame_o(sf0)
  );

  i2s_rx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNEL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable),
    .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
    .pcm_o(pcm1), .pcm_ready_o(rdy1), .short_frame_o(sf1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int rdy_cnt0 = 0, rdy_cnt1 = 0, sf_cnt0 = 0, sf_cnt1 = 0;
  int both_cnt = 0, bad1234 = 0;
  int lat0 = -1, lat1 = -1;
  int lsb_cyc [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy0 === 1'b1) begin
      rdy_cnt0++;
      lat0 = cyc - lsb_cyc[0];
      if (pcm0 === 16'h1234) bad1234++;
    end
    if (rdy1 === 1'b1) begin
      rdy_cnt1++;
      lat1 = cyc - lsb_cyc[1];
    end
    if (sf0 === 1'b1) sf_cnt0++;
    if (sf1 === 1'b1) sf_cnt1++;
    if ((rdy0 === 1'b1 && sf0 === 1'b1) || (rdy1 === 1'b1 && sf1 === 1'b1)) both_cnt++;
  end

  // One SCK period (16 clk): data and WS change while SCK is low.
  task automatic sck_bit(input logic w, input logic d, input bit mark, input int ch);
    @(negedge clk);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    if (mark) lsb_cyc[ch] = cyc;
    repeat (7) @(negedge clk);
  endtask

  // Boundary period (carries the previous slot's last bit), nbits MSB-first data, padding.
  task automatic send_slot(input logic w, input logic [15:0] word, input int nbits,
                           input int slot_len);
    sck_bit(w, 1'b0, 1'b0, 0);
    for (int i = 0; i < nbits; i++) sck_bit(w, word[15-i], (i == 15), int'(w));
    for (int i = 1 + nbits; i < slot_len; i++) sck_bit(w, 1'b0, 1'b0, 0);
  endtask

  task automatic send_frame(input logic [15:0] left, input logic [15:0] right);
    send_slot(1'b0, left, 16, 32);
    send_slot(1'b1, right, 16, 32);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (pcm0 !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_pcm0: got %h expected 0000", pcm0);
    end
    tests_run++;
    if (pcm1 !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_pcm1: got %h expected 0000", pcm1);
    end
    tests_run++;
    if ({rdy0, rdy1, sf0, sf1} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {rdy0, rdy1, sf0, sf1});
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({rdy0, rdy1, sf0, sf1, pcm0, pcm1} !== 36'd0) begin
      tests_failed++; $display("FAIL reset_release: got %h expected 0", {pcm0, pcm1});
    end
  endtask

  task automatic test_left_right;
    int r0, r1, s0, s1;
    enable = 1'b1;
    r0 = rdy_cnt0; r1 = rdy_cnt1; s0 = sf_cnt0; s1 = sf_cnt1;
    send_slot(1'b1, 16'h0000, 16, 32);  // preamble so the first left slot opens on a WS edge
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h1234);
    tests_run++;
    if (rdy_cnt0 - r0 !== 2) begin
      tests_failed++; $display("FAIL lr_count0: got %0d expected 2", rdy_cnt0 - r0);
    end
    tests_run++;
    if (pcm0 !== 16'hA5C3) begin
      tests_failed++; $display("FAIL lr_pcm0: got %h expected a5c3", pcm0);
    end
    tests_run++;
    if (rdy_cnt1 - r1 !== 2) begin
      tests_failed++; $display("FAIL lr_count1: got %0d expected 2", rdy_cnt1 - r1);
    end
    tests_run++;
    if (pcm1 !== 16'h1234) begin
      tests_failed++; $display("FAIL lr_pcm1: got %h expected 1234", pcm1);
    end
    tests_run++;
    if (lat0 !== 3) begin
      tests_failed++; $display("FAIL lr_latency0: got %0d expected 3", lat0);
    end
    tests_run++;
    if (lat1 !== 3) begin
      tests_failed++; $display("FAIL lr_latency1: got %0d expected 3", lat1);
    end
    tests_run++;
    if (bad1234 !== 0) begin
      tests_failed++; $display("FAIL lr_left_saw_right: got %0d expected 0", bad1234);
    end
    tests_run++;
    if ((sf_cnt0 - s0) + (sf_cnt1 - s1) !== 0) begin
      tests_failed++;
      $display("FAIL lr_no_short: got %0d expected 0", (sf_cnt0 - s0) + (sf_cnt1 - s1));
    end
  endtask

  task automatic test_extremes;
    int r0;
    r0 = rdy_cnt0;
    send_frame(16'h8000, 16'h0000);
    tests_run++;
    if (pcm0 !== 16'h8000) begin
      tests_failed++; $display("FAIL ext_min: got %h expected 8000", pcm0);
    end
    tests_run++;
    if (rdy_cnt0 - r0 !== 1) begin
      tests_failed++; $display("FAIL ext_count1: got %0d expected 1", rdy_cnt0 - r0);
    end
    send_frame(16'h7FFF, 16'h0001);
    tests_run++;
    if (pcm0 !== 16'h7FFF) begin
      tests_failed++; $display("FAIL ext_max: got %h expected 7fff", pcm0);
    end
    tests_run++;
    if (rdy_cnt0 - r0 !== 2) begin
      tests_failed++; $display("FAIL ext_count2: got %0d expected 2", rdy_cnt0 - r0);
    end
    tests_run++;
    if (pcm1 !== 16'h0001) begin
      tests_failed++; $display("FAIL ext_pcm1: got %h expected 0001", pcm1);
    end
  endtask

  task automatic test_short_frame;
    int r0, r1, s0, s1;
    r0 = rdy_cnt0; r1 = rdy_cnt1; s0 = sf_cnt0; s1 = sf_cnt1;
    send_slot(1'b0, 16'hFFFF, 10, 11);
    send_slot(1'b1, 16'h5A5A, 16, 32);
    tests_run++;
    if (sf_cnt0 - s0 !== 1) begin
      tests_failed++; $display("FAIL short_pulse: got %0d expected 1", sf_cnt0 - s0);
    end
    tests_run++;
    if (rdy_cnt0 - r0 !== 0) begin
      tests_failed++; $display("FAIL short_no_ready: got %0d expected 0", rdy_cnt0 - r0);
    end
    tests_run++;
    if (pcm0 !== 16'h7FFF) begin
      tests_failed++; $display("FAIL short_pcm_hold: got %h expected 7fff", pcm0);
    end
    tests_run++;
    if (sf_cnt1 - s1 !== 0) begin
      tests_failed++; $display("FAIL short_other_chan: got %0d expected 0", sf_cnt1 - s1);
    end
    tests_run++;
    if (rdy_cnt1 - r1 !== 1 || pcm1 !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL short_right_ok: got %0d/%h expected 1/5a5a", rdy_cnt1 - r1, pcm1);
    end
    r0 = rdy_cnt0; s0 = sf_cnt0;
    send_frame(16'h1357, 16'h2468);
    tests_run++;
    if (rdy_cnt0 - r0 !== 1 || pcm0 !== 16'h1357) begin
      tests_failed++;
      $display("FAIL short_recover: got %0d/%h expected 1/1357", rdy_cnt0 - r0, pcm0);
    end
    tests_run++;
    if (sf_cnt0 - s0 !== 0) begin
      tests_failed++; $display("FAIL short_recover_sf: got %0d expected 0", sf_cnt0 - s0);
    end
  endtask

  task automatic test_enable;
    int r0, r1, s0, s1;
    r0 = rdy_cnt0; r1 = rdy_cnt1; s0 = sf_cnt0; s1 = sf_cnt1;
    fork
      send_frame(16'hDEAD, 16'hFACE);
      begin
        repeat (100) @(negedge clk);
        enable = 1'b0;
        repeat (600) @(negedge clk);
        enable = 1'b1;
      end
    join
    tests_run++;
    if (rdy_cnt0 - r0 !== 0 || rdy_cnt1 - r1 !== 0) begin
      tests_failed++;
      $display("FAIL en_partial_ready: got %0d/%0d expected 0/0", rdy_cnt0 - r0, rdy_cnt1 - r1);
    end
    tests_run++;
    if (sf_cnt0 - s0 !== 0 || sf_cnt1 - s1 !== 0) begin
      tests_failed++;
      $display("FAIL en_partial_short: got %0d/%0d expected 0/0", sf_cnt0 - s0, sf_cnt1 - s1);
    end
    tests_run++;
    if (pcm0 !== 16'h1357 || pcm1 !== 16'h2468) begin
      tests_failed++; $display("FAIL en_hold: got %h/%h expected 1357/2468", pcm0, pcm1);
    end
    send_frame(16'h0F0F, 16'hF0F0);
    tests_run++;
    if (rdy_cnt0 - r0 !== 1 || pcm0 !== 16'h0F0F) begin
      tests_failed++;
      $display("FAIL en_first_left: got %0d/%h expected 1/0f0f", rdy_cnt0 - r0, pcm0);
    end
    tests_run++;
    if (rdy_cnt1 - r1 !== 1 || pcm1 !== 16'hF0F0) begin
      tests_failed++;
      $display("FAIL en_first_right: got %0d/%h expected 1/f0f0", rdy_cnt1 - r1, pcm1);
    end
  endtask

  task automatic test_reset_mid;
    int r0, r1, s0;
    r0 = rdy_cnt0; r1 = rdy_cnt1; s0 = sf_cnt0;
    fork
      send_frame(16'hCAFE, 16'hBEEF);
      begin
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pcm0 !== 16'h0000 || pcm1 !== 16'h0000) begin
          tests_failed++; $display("FAIL rstmid_pcm: got %h/%h expected 0000/0000", pcm0, pcm1);
        end
        tests_run++;
        if ({rdy0, rdy1, sf0, sf1} !== 4'b0000) begin
          tests_failed++;
          $display("FAIL rstmid_pulses: got %b expected 0000", {rdy0, rdy1, sf0, sf1});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    tests_run++;
    if (rdy_cnt0 - r0 !== 0 || sf_cnt0 - s0 !== 0 || pcm0 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_left_dropped: got %0d/%0d/%h expected 0/0/0000",
               rdy_cnt0 - r0, sf_cnt0 - s0, pcm0);
    end
    tests_run++;
    if (rdy_cnt1 - r1 !== 1 || pcm1 !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL rstmid_right_next: got %0d/%h expected 1/beef", rdy_cnt1 - r1, pcm1);
    end
    send_frame(16'h1111, 16'h2222);
    tests_run++;
    if (rdy_cnt0 - r0 !== 1 || pcm0 !== 16'h1111) begin
      tests_failed++;
      $display("FAIL rstmid_left_next: got %0d/%h expected 1/1111", rdy_cnt0 - r0, pcm0);
    end
  endtask

  task automatic test_exclusive;
    tests_run++;
    if (both_cnt !== 0) begin
      tests_failed++; $display("FAIL ready_short_overlap: got %0d expected 0", both_cnt);
    end
    tests_run++;
    if (bad1234 !== 0) begin
      tests_failed++; $display("FAIL left_never_1234: got %0d expected 0", bad1234);
    end
  endtask

  initial begin
    lsb_cyc[0] = 0;
    lsb_cyc[1] = 0;
    test_reset();
    test_left_right();
    test_extremes();
    test_short_frame();
    test_enable();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
